// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared fetch widths, constants and buffer entry type
package riscv_fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable synchronous FIFO of fetch entries; flush wins over push
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [AW:0]  count,
  output fetch_entry_t head
);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0] cnt_t;
  ptr_t wr_q, wr_d, rd_q, rd_d;
  cnt_t count_q, count_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  always_comb begin
    wr_d = flush ? '0 : push ? wr_q + ptr_t'(1) : wr_q;
    rd_d = flush ? '0 : pop ? rd_q + ptr_t'(1) : rd_q;
    count_d = flush ? '0 : count_q + cnt_t'(push) - cnt_t'(pop);
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  assign count = count_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues fetches on credit and buffers {pc, instr} for decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = riscv_fetch_pkg::DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN = riscv_fetch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] read_address,
  input  logic [XLEN-1:0] Instruction_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_err
);
  import riscv_fetch_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW:0] occ_t;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic inflight_q, inflight_d, fetch_err_q, fetch_err_d;
  logic pop, issue, push;
  logic [CW-1:0] count;
  occ_t occ;
  fetch_entry_t head;
  assign inst_valid = count != '0;
  // Credit counts buffered plus in-flight words, so a returning response always has room
  always_comb begin
    pop = inst_valid & inst_ready;
    occ = occ_t'(count) + occ_t'(inflight_q) - occ_t'(pop);
    issue = !redirect_valid & (occ < occ_t'(FIFO_DEPTH));
    push = inflight_q & !redirect_valid;
    pc_d = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : issue ? pc_q + XLEN'(PC_STEP) : pc_q;
    inflight_d = issue;
    req_pc_d = issue ? pc_q : req_pc_q;
    fetch_err_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      inflight_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      inflight_q <= inflight_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din('{pc: req_pc_q, instr: Instruction_out}),
    .count(count),
    .head(head)
  );
  assign read_address = pc_q;
  assign inst_data = inst_valid ? head.instr : '0;
  assign inst_pc = inst_valid ? head.pc : '0;
  assign fetch_err = fetch_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-level fetch model checked every cycle plus directed literal checks
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst2_n = 1'b1;
  logic ready = 1'b1;
  logic redir = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] ra, mem1, idata, ipc;
  logic ivalid, ierr;
  logic [31:0] ra2, mem2, idata2, ipc2;
  logic ivalid2, ierr2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(rst_n), .read_address(ra), .Instruction_out(mem1),
    .redirect_valid(redir), .redirect_pc(rpc), .inst_valid(ivalid),
    .inst_ready(ready), .inst_data(idata), .inst_pc(ipc), .fetch_err(ierr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(rst2_n), .read_address(ra2), .Instruction_out(mem2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .inst_valid(ivalid2),
    .inst_ready(1'b1), .inst_data(idata2), .inst_pc(ipc2), .fetch_err(ierr2)
  );

  // Instruction memory: registered read returning address ^ A5A50000
  always_ff @(posedge clk) begin
    mem1 <= ra ^ 32'hA5A5_0000;
    mem2 <= ra2 ^ 32'hA5A5_0000;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model: queue of buffered pcs, one optional outstanding request, next pc
  logic [31:0] q[$];
  bit has_inf = 0;
  logic [31:0] inf_pc = '0;
  logic [31:0] m_pc = '0;
  bit m_err = 0;
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      has_inf = 0;
      m_pc = 32'h0;
      m_err = 0;
    end else begin
      automatic bit pop = (q.size() > 0) && ready;
      automatic int occ = q.size() + int'(has_inf) - int'(pop);
      if (redir) begin
        q.delete();
        has_inf = 0;
        m_err = rpc[1:0] != 2'b00;
        m_pc = rpc & ~32'h3;
      end else begin
        m_err = 0;
        if (pop) void'(q.pop_front());
        if (has_inf) q.push_back(inf_pc);
        has_inf = occ < 2;
        if (has_inf) begin
          inf_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  logic [31:0] wlog_pc[$];
  logic [31:0] wlog_data[$];
  always @(negedge clk) begin
    chk("read_address", ra, m_pc);
    chk("inst_valid", {31'b0, ivalid}, {31'b0, q.size() > 0});
    chk("fetch_err", {31'b0, ierr}, {31'b0, m_err});
    if (q.size() > 0) begin
      chk("inst_pc", ipc, q[0]);
      chk("inst_data", idata, q[0] ^ 32'hA5A5_0000);
    end else if (!rst_n) begin
      chk("rst_inst_pc", ipc, 32'h0);
      chk("rst_inst_data", idata, 32'h0);
    end
    if (rst2_n && ivalid2) begin
      wlog_pc.push_back(ipc2);
      wlog_data.push_back(idata2);
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    rst2_n = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'b0, ivalid}, 32'h0);
    chk("rst_ra", ra, 32'h0);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    tick(); chk("s1_ra", ra, 32'h4); chk("s1_valid", {31'b0, ivalid}, 32'h0);
    tick(); chk("s2_ra", ra, 32'h8); chk("s2_valid", {31'b0, ivalid}, 32'h1);
    chk("s2_pc", ipc, 32'h0); chk("s2_data", idata, 32'hA5A5_0000);
    tick(); chk("s3_pc", ipc, 32'h4); chk("s3_data", idata, 32'hA5A5_0004);
    tick(); chk("s4_pc", ipc, 32'h8); chk("s4_data", idata, 32'hA5A5_0008);
    repeat (3) tick();
    redir = 1'b1; rpc = 32'h100;
    tick(); redir = 1'b0;
    chk("rd1_valid", {31'b0, ivalid}, 32'h0); chk("rd1_ra", ra, 32'h100);
    tick(); chk("rd2_ra", ra, 32'h104); chk("rd2_valid", {31'b0, ivalid}, 32'h0);
    tick(); chk("rd3_valid", {31'b0, ivalid}, 32'h1);
    chk("rd3_pc", ipc, 32'h100); chk("rd3_data", idata, 32'hA5A5_0100);
    repeat (2) tick();
    redir = 1'b1; rpc = 32'h102;
    tick(); redir = 1'b0;
    chk("mis1_err", {31'b0, ierr}, 32'h1); chk("mis1_ra", ra, 32'h100);
    tick(); chk("mis2_err", {31'b0, ierr}, 32'h0);
    tick(); chk("mis3_pc", ipc, 32'h100);
    tick(); chk("mis4_pc", ipc, 32'h104);
    ready = 1'b0;
    repeat (4) tick();
    chk("bp_valid", {31'b0, ivalid}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("arst_valid", {31'b0, ivalid}, 32'h0);
    chk("arst_ra", ra, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); chk("st1_ra", ra, 32'h4);
    tick(); chk("st2_ra", ra, 32'h8); chk("st2_pc", ipc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_ra", ra, 32'h8);
      chk("stall_pc", ipc, 32'h0);
      chk("stall_data", idata, 32'hA5A5_0000);
    end
    ready = 1'b1;
    tick(); chk("rel1_pc", ipc, 32'h4);
    tick(); chk("rel2_pc", ipc, 32'h8);
    tick(); chk("rel3_pc", ipc, 32'hC);
    repeat (3) tick();
    chk("wrap_len_ok", {31'b0, wlog_pc.size() >= 4}, 32'h1);
    if (wlog_pc.size() >= 4) begin
      chk("wrap_pc0", wlog_pc[0], 32'hFFFF_FFF8); chk("wrap_d0", wlog_data[0], 32'h5A5A_FFF8);
      chk("wrap_pc1", wlog_pc[1], 32'hFFFF_FFFC); chk("wrap_d1", wlog_data[1], 32'h5A5A_FFFC);
      chk("wrap_pc2", wlog_pc[2], 32'h0000_0000); chk("wrap_d2", wlog_data[2], 32'hA5A5_0000);
      chk("wrap_pc3", wlog_pc[3], 32'h0000_0004); chk("wrap_d3", wlog_data[3], 32'hA5A5_0004);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
